// File: rtl/spi_mem_arb_pkg.sv
// spi_mem_arb_pkg: shared state type and constants for the SPI SRAM arbiter
package spi_mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, GAP} arb_state_t;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;
  localparam logic [31:0] TIMEOUT_RDATA = 32'h0;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way winner pick with last-owner memory for round-robin
module rr_arb2
  import spi_mem_arb_pkg::*;
#(
  parameter bit RR = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       done_port,
  output logic       win
);
  logic last_q, last_d;
  always_comb begin
    last_d = done ? done_port : last_q;
    win = req == 2'b10 ? PORT_AUX : (req == 2'b11 && RR) ? ~last_q : PORT_CPU;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= PORT_AUX;
    else last_q <= last_d;
endmodule

// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: serialises two Wishbone masters onto one SPI SRAM controller port
module spi_mem_arbiter
  import spi_mem_arb_pkg::*;
#(
  parameter int AW = 14,
  parameter int RR = 1,
  parameter int TIMEOUT = 0,
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s0_cyc,
  input  logic [AW-1:0] s0_adr,
  input  logic          s0_we,
  input  logic [31:0]   s0_dat_i,
  input  logic [3:0]    s0_sel,
  output logic [31:0]   s0_dat_o,
  output logic          s0_ack,
  input  logic          s1_cyc,
  input  logic [AW-1:0] s1_adr,
  input  logic          s1_we,
  input  logic [31:0]   s1_dat_i,
  input  logic [3:0]    s1_sel,
  output logic [31:0]   s1_dat_o,
  output logic          s1_ack,
  output logic          m_cyc,
  output logic [AW-1:0] m_adr,
  output logic          m_we,
  output logic [31:0]   m_dat_o,
  output logic [3:0]    m_sel,
  input  logic [31:0]   m_dat_i,
  input  logic          m_ack,
  output logic [1:0]    grant,
  output logic          timeout_err
);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  arb_state_t state_q, state_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d, rdat_q, rdat_d;
  logic [3:0] sel_q, sel_d;
  logic [1:0] grant_q, grant_d, ack_q, ack_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic we_q, we_d, cyc_q, cyc_d, terr_q, terr_d, owner_q, owner_d;
  logic win, done, tmo;

  rr_arb2 #(.RR(RR != 0)) u_arb (
    .clk(clk), .rst_n(rst_n), .req({s1_cyc, s0_cyc}),
    .done(done), .done_port(owner_q), .win(win)
  );

  always_comb begin
    state_d = state_q;
    adr_d = adr_q;
    wdat_d = wdat_q;
    rdat_d = rdat_q;
    sel_d = sel_q;
    we_d = we_q;
    cyc_d = cyc_q;
    grant_d = grant_q;
    owner_d = owner_q;
    cnt_d = cnt_q;
    ack_d = 2'b00;
    terr_d = 1'b0;
    done = 1'b0;
    tmo = TIMEOUT != 0 && cnt_q == TMO_LAST;
    if (state_q == IDLE && (s0_cyc || s1_cyc)) begin
      state_d = BUSY;
      adr_d = win ? s1_adr : s0_adr;
      wdat_d = win ? s1_dat_i : s0_dat_i;
      sel_d = win ? s1_sel : s0_sel;
      we_d = win ? s1_we : s0_we;
      cyc_d = 1'b1;
      grant_d = win ? 2'b10 : 2'b01;
      owner_d = win;
      cnt_d = '0;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q + 1'b1;
      // an ack in the timeout cycle still counts as a normal completion
      if (m_ack || tmo) begin
        state_d = GAP;
        cyc_d = 1'b0;
        grant_d = 2'b00;
        done = 1'b1;
        ack_d = owner_q ? 2'b10 : 2'b01;
        terr_d = !m_ack;
        rdat_d = !m_ack ? TIMEOUT_RDATA : we_q ? rdat_q : m_dat_i;
      end
    end else if (state_q == GAP) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      adr_q <= '0;
      wdat_q <= '0;
      rdat_q <= '0;
      sel_q <= '0;
      we_q <= 1'b0;
      cyc_q <= 1'b0;
      grant_q <= '0;
      owner_q <= 1'b0;
      cnt_q <= '0;
      ack_q <= '0;
      terr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q <= adr_d;
      wdat_q <= wdat_d;
      rdat_q <= rdat_d;
      sel_q <= sel_d;
      we_q <= we_d;
      cyc_q <= cyc_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      cnt_q <= cnt_d;
      ack_q <= ack_d;
      terr_q <= terr_d;
    end

  assign m_cyc = cyc_q;
  assign m_adr = adr_q;
  assign m_we = we_q;
  assign m_dat_o = wdat_q;
  assign m_sel = sel_q;
  assign grant = grant_q;
  assign timeout_err = terr_q;
  assign s0_ack = ack_q[0];
  assign s1_ack = ack_q[1];
  assign s0_dat_o = rdat_q;
  assign s1_dat_o = rdat_q;
endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb_spi_mem_arbiter: directed and randomized checks of two arbiter configurations against a transaction model
module tb_spi_mem_arbiter;
  localparam int AW = 14;
  typedef struct packed {
    logic we;
    logic [AW-1:0] adr;
    logic [31:0] dat;
    logic [3:0] sel;
  } req_t;
  int rr_p [2] = '{1, 0};
  int tmo_p [2] = '{8, 0};
  logic clk = 1'b0, rst_n;
  logic cyc [2][2], we [2][2], ack [2][2];
  logic [AW-1:0] adr [2][2];
  logic [31:0] wd [2][2], rd [2][2];
  logic [3:0] sel [2][2];
  logic mcyc [2], mwe [2], mack [2], terr [2];
  logic [AW-1:0] madr [2];
  logic [31:0] mdo [2], mdi [2];
  logic [3:0] msel [2];
  logic [1:0] gnt [2];
  int total = 0, bad = 0;
  int own [2], cnt [2], last [2], rcnt [2], rdly [2], dmode [2], obs_busy [2];
  bit gap [2], e_cyc [2], e_we [2], e_terr [2], obs_ta [2], obs_t [2];
  bit pend [2][2], e_ack [2][2];
  logic [AW-1:0] e_adr [2];
  logic [31:0] e_dat [2], e_rd [2];
  logic [3:0] e_sel [2];
  logic [1:0] e_gnt [2], pg [2];
  req_t rq [2][2][$];
  int glog [2][$];
  bit randreq = 0, spur = 0, fixen = 0;
  logic [31:0] fixdat = '0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    spi_mem_arbiter #(.AW(AW), .RR(g == 0 ? 1 : 0), .TIMEOUT(g == 0 ? 8 : 0), .TW(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .s0_cyc(cyc[g][0]), .s0_adr(adr[g][0]), .s0_we(we[g][0]), .s0_dat_i(wd[g][0]),
      .s0_sel(sel[g][0]), .s0_dat_o(rd[g][0]), .s0_ack(ack[g][0]),
      .s1_cyc(cyc[g][1]), .s1_adr(adr[g][1]), .s1_we(we[g][1]), .s1_dat_i(wd[g][1]),
      .s1_sel(sel[g][1]), .s1_dat_o(rd[g][1]), .s1_ack(ack[g][1]),
      .m_cyc(mcyc[g]), .m_adr(madr[g]), .m_we(mwe[g]), .m_dat_o(mdo[g]), .m_sel(msel[g]),
      .m_dat_i(mdi[g]), .m_ack(mack[g]), .grant(gnt[g]), .timeout_err(terr[g])
    );
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      own[k] = -1; gap[k] = 0; cnt[k] = 0; last[k] = 1;
      e_cyc[k] = 0; e_we[k] = 0; e_terr[k] = 0; e_adr[k] = '0; e_dat[k] = '0;
      e_rd[k] = '0; e_sel[k] = '0; e_gnt[k] = '0; pg[k] = '0;
      mack[k] = 0; mdi[k] = '0; rcnt[k] = 0; rdly[k] = 0;
      for (int p = 0; p < 2; p++) begin
        e_ack[k][p] = 0; pend[k][p] = 0; cyc[k][p] = 0; we[k][p] = 0;
        adr[k][p] = '0; wd[k][p] = '0; sel[k][p] = '0; rq[k][p].delete();
      end
    end
  endtask

  task automatic clr_obs();
    for (int k = 0; k < 2; k++) begin
      obs_busy[k] = 0; obs_ta[k] = 0; obs_t[k] = 0; glog[k].delete();
    end
  endtask

  task automatic issue(int k, int p, logic w, logic [AW-1:0] a, logic [31:0] d, logic [3:0] s);
    req_t r;
    r.we = w; r.adr = a; r.dat = d; r.sel = s;
    rq[k][p].push_back(r);
  endtask

  task automatic check_out(int k);
    chk($sformatf("k%0d_ctl", k), {mcyc[k], gnt[k], ack[k][1], ack[k][0], terr[k]},
        {e_cyc[k], e_gnt[k], e_ack[k][1], e_ack[k][0], e_terr[k]});
    chk($sformatf("k%0d_adr", k), madr[k], e_adr[k]);
    chk($sformatf("k%0d_wesel", k), {mwe[k], msel[k]}, {e_we[k], e_sel[k]});
    chk($sformatf("k%0d_wdat", k), mdo[k], e_dat[k]);
    chk($sformatf("k%0d_rd0", k), rd[k][0], e_rd[k]);
    chk($sformatf("k%0d_rd1", k), rd[k][1], e_rd[k]);
    if (gnt[k] != 2'b00 && pg[k] == 2'b00) glog[k].push_back(int'(gnt[k]));
    pg[k] = gnt[k];
    obs_busy[k] += int'(mcyc[k]);
    if (terr[k] && ack[k][0]) obs_ta[k] = 1;
    if (terr[k]) obs_t[k] = 1;
  endtask

  task automatic drive(int k);
    req_t r;
    for (int p = 0; p < 2; p++) begin
      r.we = 1'($urandom); r.adr = AW'($urandom); r.dat = $urandom; r.sel = 4'($urandom);
      if (e_ack[k][p]) begin
        pend[k][p] = 0; cyc[k][p] = 0;
      end else if (!pend[k][p]) begin
        if (rq[k][p].size() > 0) begin
          r = rq[k][p].pop_front();
          pend[k][p] = 1;
        end else if (randreq && $urandom_range(0, 3) == 0) pend[k][p] = 1;
        if (pend[k][p] || randreq) begin
          cyc[k][p] = pend[k][p]; we[k][p] = r.we; adr[k][p] = r.adr; wd[k][p] = r.dat; sel[k][p] = r.sel;
        end
      end
    end
    if (own[k] >= 0) begin
      mack[k] = rcnt[k] == rdly[k];
      rcnt[k]++;
    end else mack[k] = spur && $urandom_range(0, 4) == 0;
    mdi[k] = fixen ? fixdat : $urandom;
  endtask

  // transaction-level view: who owns the bus, when it must end, what the requester sees next
  task automatic step(int k);
    int w;
    bit fin;
    e_ack[k][0] = 0; e_ack[k][1] = 0; e_terr[k] = 0;
    if (own[k] >= 0) begin
      fin = mack[k] || (tmo_p[k] != 0 && cnt[k] == tmo_p[k] - 1);
      if (fin) begin
        e_ack[k][own[k]] = 1;
        e_terr[k] = !mack[k];
        if (!mack[k]) e_rd[k] = '0;
        else if (!e_we[k]) e_rd[k] = mdi[k];
        last[k] = own[k]; own[k] = -1; gap[k] = 1; e_cyc[k] = 0; e_gnt[k] = 2'b00;
      end else cnt[k]++;
    end else if (gap[k]) gap[k] = 0;
    else if (cyc[k][0] || cyc[k][1]) begin
      w = (cyc[k][0] && cyc[k][1]) ? (rr_p[k] != 0 ? 1 - last[k] : 0) : (cyc[k][1] ? 1 : 0);
      e_adr[k] = adr[k][w]; e_we[k] = we[k][w]; e_dat[k] = wd[k][w]; e_sel[k] = sel[k][w];
      own[k] = w; cnt[k] = 0; e_cyc[k] = 1; e_gnt[k] = w == 1 ? 2'b10 : 2'b01;
      rcnt[k] = 0;
      rdly[k] = dmode[k] < 0 ? int'($urandom_range(0, 9)) : dmode[k];
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_out(k);
      drive(k);
      step(k);
    end
  endtask

  task automatic wait_idle(int k, int max);
    int n = 0;
    while ((pend[k][0] || pend[k][1] || rq[k][0].size() > 0 || rq[k][1].size() > 0 ||
            own[k] >= 0 || gap[k]) && n < max) begin
      cycle();
      n++;
    end
    chk($sformatf("k%0d_idle_in_budget", k), n < max, 1'b1);
  endtask

  initial begin
    int n;
    dmode[0] = 2; dmode[1] = 2;
    rst_n = 1'b0;
    model_reset();
    clr_obs();
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();

    issue(0, 0, 0, 14'h0100, 0, 4'hf); issue(0, 1, 0, 14'h0200, 0, 4'hf);
    wait_idle(0, 60);
    issue(0, 0, 0, 14'h0101, 0, 4'hf); issue(0, 1, 0, 14'h0201, 0, 4'hf);
    wait_idle(0, 60);
    chk("rr_count", glog[0].size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_seq%0d", i), i < glog[0].size() ? glog[0][i] : -1, i % 2 == 0 ? 1 : 2);

    clr_obs();
    for (int i = 0; i < 3; i++) issue(1, 0, 1, AW'(i), 32'(i), 4'hf);
    issue(1, 1, 1, 14'h3fff, 32'hdead_beef, 4'h1);
    wait_idle(1, 100);
    chk("fp_count", glog[1].size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("fp_seq%0d", i), i < glog[1].size() ? glog[1][i] : -1, i < 3 ? 1 : 2);

    fixen = 1; fixdat = 32'hA5A5_1234; dmode[0] = 5; clr_obs();
    issue(0, 0, 0, 14'h0010, 32'h0, 4'hf);
    wait_idle(0, 40);
    chk("single_rd", rd[0][0], 32'hA5A5_1234);
    chk("single_adr", madr[0], 14'h0010);
    chk("single_busy", obs_busy[0], 6);
    chk("single_grant", glog[0].size() > 0 ? glog[0][0] : -1, 1);

    fixdat = 32'h1111_1111; dmode[0] = 2;
    issue(0, 0, 0, 14'h0020, 32'h0, 4'hf);
    wait_idle(0, 40);
    fixen = 0;
    issue(0, 1, 1, 14'h0123, 32'hFFFF_FFFF, 4'b0011);
    n = 0;
    while (own[0] < 0 && n < 10) begin cycle(); n++; end
    @(posedge clk); #1;
    chk("wr_mdat", mdo[0], 32'hFFFF_FFFF);
    chk("wr_msel", msel[0], 4'b0011);
    chk("wr_mwe", mwe[0], 1'b1);
    wait_idle(0, 40);
    chk("wr_keep_rd0", rd[0][0], 32'h1111_1111);
    chk("wr_keep_rd1", rd[0][1], 32'h1111_1111);

    clr_obs(); dmode[0] = 1000;
    issue(0, 0, 0, 14'h0030, 32'h0, 4'hf);
    wait_idle(0, 40);
    chk("tmo_busy", obs_busy[0], 8);
    chk("tmo_pulse", obs_ta[0], 1'b1);
    chk("tmo_rd", rd[0][0], 32'h0);
    clr_obs(); dmode[0] = 7; fixen = 1; fixdat = 32'h2222_2222;
    issue(0, 0, 0, 14'h0031, 32'h0, 4'hf);
    wait_idle(0, 40);
    chk("late_busy", obs_busy[0], 8);
    chk("late_no_terr", obs_t[0], 1'b0);
    chk("late_rd", rd[0][0], 32'h2222_2222);
    fixen = 0;

    dmode[0] = 1000;
    issue(0, 1, 0, 14'h0040, 32'h0, 4'hf);
    n = 0;
    while (own[0] < 0 && n < 10) begin cycle(); n++; end
    repeat (2) cycle();
    chk("pre_rst_mcyc", mcyc[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("k%0d_rst_ctl", k), {mcyc[k], gnt[k], ack[k][1], ack[k][0], terr[k]}, 6'b0);
      chk($sformatf("k%0d_rst_rd", k), rd[k][0], 32'h0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    dmode[0] = 2; clr_obs();
    issue(0, 0, 0, 14'h0050, 0, 4'hf); issue(0, 1, 0, 14'h0060, 0, 4'hf);
    wait_idle(0, 60);
    chk("post_rst_first", glog[0].size() > 0 ? glog[0][0] : -1, 1);
    chk("post_rst_second", glog[0].size() > 1 ? glog[0][1] : -1, 2);

    dmode[0] = -1; dmode[1] = -1; randreq = 1; spur = 1;
    repeat (3000) cycle();
    randreq = 0; spur = 0;
    wait_idle(0, 100);
    wait_idle(1, 100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
